hedios_write_arbiter: RTL



---
 rtl/hedios_arb_pkg.sv | 10 +
 rtl/hedios_write_arbiter_if.sv | 40 ++++
 rtl/hedios_rr_picker.sv | 31 +++
 rtl/hedios_write_arbiter.sv | 104 ++++++++++
 4 files changed

// File: rtl/hedios_arb_pkg.sv
// rtl/hedios_arb_pkg.sv - shared width helper and drop counter width for the write arbiter
package hedios_arb_pkg;

    localparam int DROP_CNT_W = 8;

    function automatic int src_width(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/hedios_write_arbiter_if.sv
// rtl/hedios_write_arbiter_if.sv - writer/register bus of the arbiter; HEDIOS_ARB_DROP_COUNT_EN adds drop_count
interface hedios_write_arbiter_if
    import hedios_arb_pkg::*;
#(
    parameter int REQ_COUNT = 2,
    parameter int DEPTH     = 16
);
    localparam int SRC_W = src_width(REQ_COUNT);

    logic [REQ_COUNT-1:0]       req_valid;
    logic [REQ_COUNT*DEPTH-1:0] req_data;
    logic [REQ_COUNT-1:0]       req_done;
    logic                       wr_en;
    logic [DEPTH-1:0]           wr_data;
    logic [SRC_W-1:0]           wr_src;
    logic [REQ_COUNT-1:0]       drop_flag;
    logic                       clear_drop;
`ifdef HEDIOS_ARB_DROP_COUNT_EN
    logic [DROP_CNT_W-1:0]      drop_count;

    modport master (
        output req_valid, req_data, clear_drop,
        input  req_done, wr_en, wr_data, wr_src, drop_flag, drop_count
    );
    modport slave (
        input  req_valid, req_data, clear_drop,
        output req_done, wr_en, wr_data, wr_src, drop_flag, drop_count
    );
`else
    modport master (
        output req_valid, req_data, clear_drop,
        input  req_done, wr_en, wr_data, wr_src, drop_flag
    );
    modport slave (
        input  req_valid, req_data, clear_drop,
        output req_done, wr_en, wr_data, wr_src, drop_flag
    );
`endif

endinterface

// File: rtl/hedios_rr_picker.sv
// rtl/hedios_rr_picker.sv - combinational round-robin pick starting after last_grant
module hedios_rr_picker
    import hedios_arb_pkg::*;
#(
    parameter int REQ_COUNT = 2,
    localparam int SRC_W    = src_width(REQ_COUNT)
) (
    input  logic [REQ_COUNT-1:0] pending,
    input  logic [SRC_W-1:0]     last_grant,
    output logic                 grant_valid,
    output logic [SRC_W-1:0]     grant_idx
);

    // scan from farthest to nearest so the nearest pending writer after last_grant is written last and wins
    always_comb begin
        grant_valid = 1'b0;
        grant_idx   = '0;
        for (int k = REQ_COUNT; k >= 1; k--) begin
            int               pos;
            logic [SRC_W-1:0] sel;
            pos = int'(last_grant) + k;
            if (pos >= REQ_COUNT) pos = pos - REQ_COUNT;
            sel = SRC_W'(pos);
            if (pending[sel]) begin
                grant_valid = 1'b1;
                grant_idx   = sel;
            end
        end
    end

endmodule

// File: rtl/hedios_write_arbiter.sv
// rtl/hedios_write_arbiter.sv - round-robin arbiter for one register write port; HEDIOS_ARB_DROP_COUNT_EN adds drop_count
module hedios_write_arbiter
    import hedios_arb_pkg::*;
#(
    parameter int REQ_COUNT = 2,
    parameter int DEPTH     = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    hedios_write_arbiter_if.slave bus
);
    localparam int SRC_W = src_width(REQ_COUNT);

    logic [REQ_COUNT-1:0] pending;
    logic [DEPTH-1:0]     data_buf [REQ_COUNT];
    logic [SRC_W-1:0]     last_grant;
    logic                 grant_valid;
    logic [SRC_W-1:0]     grant_idx;
    logic [REQ_COUNT-1:0] granted;
    logic [REQ_COUNT-1:0] drop_now;

    logic                 wr_en_q;
    logic [DEPTH-1:0]     wr_data_q;
    logic [SRC_W-1:0]     wr_src_q;
    logic [REQ_COUNT-1:0] req_done_q;
    logic [REQ_COUNT-1:0] drop_flag_q;

    hedios_rr_picker #(.REQ_COUNT(REQ_COUNT)) u_picker (
        .pending     (pending),
        .last_grant  (last_grant),
        .grant_valid (grant_valid),
        .grant_idx   (grant_idx)
    );

    // one-hot of the writer served this cycle; a re-request is only lost when its writer is not being served
    always_comb begin
        granted = '0;
        if (grant_valid) granted[grant_idx] = 1'b1;
        drop_now = bus.req_valid & pending & ~granted;
    end

    // capture requests into per-writer buffers; a served writer may reload in the same cycle
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pending <= '0;
            for (int i = 0; i < REQ_COUNT; i++) data_buf[i] <= '0;
        end else begin
            for (int i = 0; i < REQ_COUNT; i++) begin
                if (bus.req_valid[i] && (!pending[i] || granted[i])) begin
                    pending[i]  <= 1'b1;
                    data_buf[i] <= bus.req_data[i*DEPTH +: DEPTH];
                end else if (granted[i]) begin
                    pending[i] <= 1'b0;
                end
            end
        end
    end

    // register the granted write; data and source hold when nobody is pending
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_en_q    <= 1'b0;
            wr_data_q  <= '0;
            wr_src_q   <= '0;
            req_done_q <= '0;
            last_grant <= SRC_W'(REQ_COUNT - 1);
        end else if (grant_valid) begin
            wr_en_q    <= 1'b1;
            wr_data_q  <= data_buf[grant_idx];
            wr_src_q   <= grant_idx;
            req_done_q <= granted;
            last_grant <= grant_idx;
        end else begin
            wr_en_q    <= 1'b0;
            req_done_q <= '0;
        end
    end

    // sticky drop flags; a drop in the clearing cycle survives the clear
    always_ff @(posedge clk or posedge rst) begin
        if (rst) drop_flag_q <= '0;
        else     drop_flag_q <= (bus.clear_drop ? '0 : drop_flag_q) | drop_now;
    end

    assign bus.wr_en     = wr_en_q;
    assign bus.wr_data   = wr_data_q;
    assign bus.wr_src    = wr_src_q;
    assign bus.req_done  = req_done_q;
    assign bus.drop_flag = drop_flag_q;

`ifdef HEDIOS_ARB_DROP_COUNT_EN
    logic [DROP_CNT_W-1:0] drop_count_q;

    // saturating count of cycles with at least one drop; a drop while clearing restarts at 1
    always_ff @(posedge clk or posedge rst) begin
        if (rst)                                   drop_count_q <= '0;
        else if (bus.clear_drop)                   drop_count_q <= (|drop_now) ? DROP_CNT_W'(1) : '0;
        else if ((|drop_now) && (drop_count_q != '1)) drop_count_q <= drop_count_q + 1'b1;
    end

    assign bus.drop_count = drop_count_q;
`endif

endmodule
